register_bank: RTL and testbench

- Clocked 16 x 32-bit ARM register file; responder end of the decode stage's register-bank read interface.
- Decode drives an address and toggles a trigger; this block returns the register contents and raises ready.
- A second toggle-handshake port accepts register writes from the writeback stage.
- Sits between decode (reader) and writeback (writer); R15 is an ordinary storage entry here.

---
 rtl/register_bank.sv | 100 ++++++++++
 tb/tb_register_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: 16 x 32-bit register file. Decode reads it through a
// two-phase (toggle) request / ready port, and writeback writes it through
// a second toggle port that acknowledges by toggling ackOutWB.
module register_bank #(
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        triggerInRB,
  input  logic [3:0]  addrInRB,
  output logic [31:0] dataOutRB,
  output logic        readyOutRB,
  input  logic        triggerInWB,
  input  logic [3:0]  addrInWB,
  input  logic [31:0] dataInWB,
  output logic        ackOutWB
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0] r_regs [16];
  logic        r_trig_rd_seen;
  logic        r_trig_wb_seen;
  logic        r_ready;
  logic        r_ack;
  logic [3:0]  r_addr;
  logic [1:0]  r_cnt;
  logic [31:0] r_data;
  state_t      r_state;

  logic        w_req_rd;
  logic        w_req_wb;
  logic [31:0] w_rd_data;

  // A request is any level difference between a trigger and its last
  // accepted level; the seen-level only moves on acceptance, so a toggle
  // that arrives while busy stays pending until the FSM is back in IDLE.
  assign w_req_rd = triggerInRB != r_trig_rd_seen;
  assign w_req_wb = triggerInWB != r_trig_wb_seen;

  // Write-first bypass: a write accepted in the DONE cycle to the same
  // index wins over the stored value.
  assign w_rd_data = (w_req_wb && (addrInWB == r_addr)) ? dataInWB : r_regs[r_addr];

  // Ready drops combinationally with the trigger so a requester that waits
  // for ready right after toggling never sees the stale idle level.
  assign readyOutRB = r_ready & ~w_req_rd;
  assign dataOutRB  = r_data;
  assign ackOutWB   = r_ack;

  // Writeback port: one write per cycle, always accepted, ack toggles next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        r_regs[i] <= (i == 15) ? RESET_PC : 32'h0;
      r_trig_wb_seen <= triggerInWB;
      r_ack          <= 1'b0;
    end else if (w_req_wb) begin
      r_regs[addrInWB] <= dataInWB;
      r_trig_wb_seen   <= triggerInWB;
      r_ack            <= ~r_ack;
    end
  end

  // Read FSM: accept in IDLE, count out the latency in WAIT, deliver in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_trig_rd_seen <= triggerInRB;
      r_ready        <= 1'b1;
      r_data         <= 32'h0;
      r_addr         <= 4'h0;
      r_cnt          <= 2'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_rd) begin
            r_addr         <= addrInRB;
            r_trig_rd_seen <= triggerInRB;
            r_ready        <= 1'b0;
            r_cnt          <= 2'(READ_LATENCY - 1);
            r_state        <= (READ_LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_data  <= w_rd_data;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a latency-1 instance (nonzero RESET_PC) for the
// functional table, collision and back-to-back cases, and a latency-3
// instance for the longer latency and reset-during-read cases.
module tb_register_bank;

  localparam logic [31:0] PC0 = 32'h0000_0100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        reset = 1'b1;
  logic        triggerInRB = 1'b0, triggerInWB = 1'b0;
  logic [3:0]  addrInRB = '0, addrInWB = '0;
  logic [31:0] dataInWB = '0;
  logic [31:0] dataOutRB;
  logic        readyOutRB, ackOutWB;

  // latency-3 instance
  logic        reset3 = 1'b1;
  logic        trigRB3 = 1'b0, trigWB3 = 1'b0;
  logic [3:0]  addrRB3 = '0, addrWB3 = '0;
  logic [31:0] dataWB3 = '0;
  logic [31:0] dataOut3;
  logic        ready3, ack3;

  register_bank #(.READ_LATENCY(1), .RESET_PC(PC0)) dut (
    .clk(clk), .reset(reset),
    .triggerInRB(triggerInRB), .addrInRB(addrInRB),
    .dataOutRB(dataOutRB), .readyOutRB(readyOutRB),
    .triggerInWB(triggerInWB), .addrInWB(addrInWB),
    .dataInWB(dataInWB), .ackOutWB(ackOutWB));

  register_bank #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3),
    .triggerInRB(trigRB3), .addrInRB(addrRB3),
    .dataOutRB(dataOut3), .readyOutRB(ready3),
    .triggerInWB(trigWB3), .addrInWB(addrWB3),
    .dataInWB(dataWB3), .ackOutWB(ack3));

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    logic prev;
    @(negedge clk);
    prev = ackOutWB;
    addrInWB = a; dataInWB = d; triggerInWB = ~triggerInWB;
    @(negedge clk);
    chk("wb_ack_toggle", {31'h0, ackOutWB}, {31'h0, ~prev});
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e);
    int n;
    @(negedge clk);
    addrInRB = a; triggerInRB = ~triggerInRB;
    exp_q.push_back(e);
    #1 chk("rd_ready_drop", {31'h0, readyOutRB}, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!readyOutRB && n < 20);
    chk("rd_latency", n, 2);
    chk("rd_data", dataOutRB, pop_exp());
  endtask

  initial begin
    int n;
    bit seen_hi;

    // ---- reset with a high read trigger: nothing must start afterwards
    triggerInRB = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, readyOutRB}, 32'h1);
    chk("rst_data", dataOutRB, 32'h0);
    chk("rst_ack", {31'h0, ackOutWB}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_phantom", {31'h0, readyOutRB}, 32'h1);
    do_read(4'd15, PC0);
    do_read(4'd7, 32'h0);

    // ---- table-driven writes and reads
    tbl.push_back('{1'b1, 4'd3, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 4'd3, 32'hDEAD_BEEF});
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b1, 4'(i), 32'hA0 + i});
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 4'(i), 32'hA0 + i});
    foreach (tbl[k]) begin
      if (tbl[k].is_wr) do_write(tbl[k].addr, tbl[k].data);
      else              do_read(tbl[k].addr, tbl[k].data);
    end

    // ---- collision: write to R5 lands in the DONE cycle of a read of R5
    @(negedge clk);
    addrInRB = 4'd5; triggerInRB = ~triggerInRB;
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    addrInWB = 4'd5; dataInWB = 32'h1234_5678; triggerInWB = ~triggerInWB;
    @(negedge clk);
    chk("coll_ready", {31'h0, readyOutRB}, 32'h1);
    chk("coll_data", dataOutRB, pop_exp());
    do_read(4'd5, 32'h1234_5678);

    // ---- back-to-back: second toggle one cycle after the first
    @(negedge clk);
    addrInRB = 4'd1; triggerInRB = ~triggerInRB;
    exp_q.push_back(32'hA1);
    @(negedge clk);
    addrInRB = 4'd2; triggerInRB = ~triggerInRB;
    exp_q.push_back(32'hA2);
    #1 chk("b2b_busy1", {31'h0, readyOutRB}, 32'h0);
    @(negedge clk);
    chk("b2b_busy2", {31'h0, readyOutRB}, 32'h0);
    chk("b2b_first", dataOutRB, pop_exp());
    n = 0;
    do begin @(negedge clk); n++; end while (!readyOutRB && n < 20);
    chk("b2b_wait", n, 2);
    chk("b2b_second", dataOutRB, pop_exp());

    // ---- latency-3 instance: write, timed read, then reset mid-read
    reset3 = 1'b0;
    @(negedge clk);
    addrWB3 = 4'd4; dataWB3 = 32'h0000_CAFE; trigWB3 = ~trigWB3;
    @(negedge clk);
    chk("l3_ack", {31'h0, ack3}, 32'h1);
    addrRB3 = 4'd4; trigRB3 = ~trigRB3;
    exp_q.push_back(32'h0000_CAFE);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready3 && n < 20);
    chk("l3_latency", n, 4);
    chk("l3_data", dataOut3, pop_exp());

    @(negedge clk);
    trigRB3 = ~trigRB3;
    @(negedge clk);               // request accepted, FSM now waiting
    chk("l3_busy", {31'h0, ready3}, 32'h0);
    reset3 = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'h0, ready3}, 32'h1);
    chk("mid_rst_data", dataOut3, 32'h0);
    reset3 = 1'b0;
    seen_hi = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!ready3 || dataOut3 != 32'h0) seen_hi = 1'b1;
    end
    chk("mid_rst_no_completion", {31'h0, seen_hi}, 32'h0);
    chk("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
